store_buffer: RTL and testbench

Store-side counterpart of the load extender in the memory stage: accepts sb/sh/sw requests from the pipeline, replicates the data across the byte lanes, generates byte strobes and checks address alignment. Aligned stores are queued in a small FIFO and drained one at a time over the sram-like data port toward the AXI bridge. An empty flag lets loads wait until earlier stores have retired.

---
 rtl/store_buffer_pkg.sv | 28 ++
 rtl/store_buffer_if.sv | 33 +++
 rtl/store_buffer_align.sv | 33 +++
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared encodings and entry layout for the store buffer and its align stage.
package store_buffer_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [1:0]        size;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline store port plus sram-like write port of the store buffer.
interface store_buffer_if;
   import store_buffer_pkg::*;

   logic              st_valid;
   logic              st_ready;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic [1:0]        st_length;
   logic              st_ades;
   logic              sb_empty;
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [STRB_W-1:0] data_wstrb;
   logic              data_addr_ok;
   logic              data_data_ok;

   modport slave (
      input  st_valid, st_addr, st_data, st_length, data_addr_ok, data_data_ok,
      output st_ready, st_ades, sb_empty, data_req, data_wr, data_size,
             data_addr, data_wdata, data_wstrb
   );

   modport master (
      output st_valid, st_addr, st_data, st_length, data_addr_ok, data_data_ok,
      input  st_ready, st_ades, sb_empty, data_req, data_wr, data_size,
             data_addr, data_wdata, data_wstrb
   );

endinterface

// File: rtl/store_buffer_align.sv
// Lane replication, byte strobes and misalignment detection for one store.
module store_align
   import store_buffer_pkg::*;
(
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic [1:0]        i_length,
   output logic [1:0]        o_size,
   output logic [DATA_W-1:0] o_wdata,
   output logic [STRB_W-1:0] o_wstrb,
   output logic              o_ades
);

   // Word wins over halfword when both length bits are set.
   always_comb begin
      o_size  = SIZE_B;
      o_wdata = {4{i_data[7:0]}};
      o_wstrb = STRB_W'(4'b0001 << i_addr[1:0]);
      o_ades  = 1'b0;
      if (i_length[1]) begin
         o_size  = SIZE_W;
         o_wdata = i_data;
         o_wstrb = 4'b1111;
         o_ades  = |i_addr[1:0];
      end else if (i_length[0]) begin
         o_size  = SIZE_H;
         o_wdata = {2{i_data[15:0]}};
         o_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
         o_ades  = i_addr[0];
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO draining aligned stores one at a time over an sram-like write port.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          resetn,
   store_buffer_if.slave sb_if
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   sb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   state_e           r_state;
   state_e           w_state_nxt;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_req;
   logic              w_ades;
   logic [1:0]        w_size;
   logic [DATA_W-1:0] w_wdata;
   logic [STRB_W-1:0] w_wstrb;
   sb_entry_t         w_entry;
   sb_entry_t         w_head;

   store_align u_align (
      .i_addr   (sb_if.st_addr),
      .i_data   (sb_if.st_data),
      .i_length (sb_if.st_length),
      .o_size   (w_size),
      .o_wdata  (w_wdata),
      .o_wstrb  (w_wstrb),
      .o_ades   (w_ades)
   );

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   // Fullness is taken before any same-cycle pop, so a full buffer never accepts.
   assign w_push  = sb_if.st_valid & ~w_full & ~w_ades;

   always_comb begin
      w_entry       = '0;
      w_entry.addr  = sb_if.st_addr;
      w_entry.size  = w_size;
      w_entry.wdata = w_wdata;
      w_entry.wstrb = w_wstrb;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (!w_empty && sb_if.data_addr_ok) w_state_nxt = ST_WAIT;
         ST_WAIT: if (sb_if.data_data_ok)             w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_req = 1'b0;
      w_pop = 1'b0;
      case (r_state)
         ST_IDLE: w_req = ~w_empty;
         ST_WAIT: w_pop = sb_if.data_data_ok;
         default: ;
      endcase
   end

   assign w_head = r_mem[r_rd_ptr];

   assign sb_if.st_ready   = ~w_full;
   assign sb_if.st_ades    = sb_if.st_valid & w_ades;
   assign sb_if.sb_empty   = w_empty & (r_state == ST_IDLE);
   assign sb_if.data_req   = w_req;
   assign sb_if.data_wr    = 1'b1;
   assign sb_if.data_size  = w_head.size;
   assign sb_if.data_addr  = w_head.addr;
   assign sb_if.data_wdata = w_head.wdata;
   assign sb_if.data_wstrb = w_head.wstrb;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model checked every cycle.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   bit   waiting = 1'b0;
   bit   m_push, m_pop, m_acc;

   always #5 clk = ~clk;

   store_buffer_if sb_if();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .sb_if  (sb_if.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit misal(input logic [31:0] a, input logic [1:0] len);
      if (len >= 2) return (a % 4) != 0;
      if (len == 1) return (a % 2) != 0;
      return 1'b0;
   endfunction

   function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d, input logic [1:0] len);
      exp_t e;
      e.addr = a;
      if (len >= 2) begin
         e.size = 2; e.wdata = d; e.wstrb = 4'd15;
      end else if (len == 1) begin
         e.size  = 1;
         e.wdata = (d & 32'h0000_FFFF) * 32'h0001_0001;
         e.wstrb = ((a % 4) >= 2) ? 4'd12 : 4'd3;
      end else begin
         e.size  = 0;
         e.wdata = (d & 32'h0000_00FF) * 32'h0101_0101;
         e.wstrb = 4'(1 << (a % 4));
      end
      return e;
   endfunction

   // Reference model: a queue of outstanding stores plus an "accepted, awaiting completion" flag.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q.delete();
         waiting = 1'b0;
      end else begin
         m_push = sb_if.st_valid && (q.size() < DEPTH) && !misal(sb_if.st_addr, sb_if.st_length);
         m_pop  = waiting && sb_if.data_data_ok;
         m_acc  = !waiting && (q.size() > 0) && sb_if.data_addr_ok;
         if (m_pop) begin
            void'(q.pop_front());
            waiting = 1'b0;
         end
         if (m_acc) waiting = 1'b1;
         if (m_push) q.push_back(mk(sb_if.st_addr, sb_if.st_data, sb_if.st_length));
      end
   end

   always @(negedge clk) begin
      check("st_ready", 32'(sb_if.st_ready), 32'(q.size() < DEPTH));
      check("sb_empty", 32'(sb_if.sb_empty), 32'(q.size() == 0 && !waiting));
      check("data_req", 32'(sb_if.data_req), 32'(!waiting && q.size() > 0));
      check("data_wr", 32'(sb_if.data_wr), 32'd1);
      check("st_ades", 32'(sb_if.st_ades),
            32'(sb_if.st_valid && misal(sb_if.st_addr, sb_if.st_length)));
      if (q.size() > 0) begin
         check("head_addr", sb_if.data_addr, q[0].addr);
         check("head_size", 32'(sb_if.data_size), 32'(q[0].size));
         check("head_wdata", sb_if.data_wdata, q[0].wdata);
         check("head_wstrb", 32'(sb_if.data_wstrb), 32'(q[0].wstrb));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] len);
      sb_if.st_valid  = 1'b1;
      sb_if.st_addr   = a;
      sb_if.st_data   = d;
      sb_if.st_length = len;
      cyc();
      sb_if.st_valid = 1'b0;
   endtask

   task automatic accept();
      int n = 0;
      while (!sb_if.data_req && n < 20) begin
         cyc();
         n++;
      end
      check("accept_req", 32'(sb_if.data_req), 32'd1);
      sb_if.data_addr_ok = 1'b1;
      cyc();
      sb_if.data_addr_ok = 1'b0;
   endtask

   task automatic drain(input logic [31:0] exp_addr);
      int n = 0;
      while (!sb_if.data_req && n < 20) begin
         cyc();
         n++;
      end
      check("drain_addr", sb_if.data_addr, exp_addr);
      accept();
      sb_if.data_data_ok = 1'b1;
      cyc();
      sb_if.data_data_ok = 1'b0;
   endtask

   function automatic logic [31:0] wrap_addr(input int k);
      case (k % 3)
         0:       return 32'h6000 + 32'(k * 8) + 32'(k % 4);
         1:       return 32'h6000 + 32'(k * 8) + 32'((k % 2) * 2);
         default: return 32'h6000 + 32'(k * 8);
      endcase
   endfunction

   initial begin
      resetn             = 1'b0;
      sb_if.st_valid     = 1'b0;
      sb_if.st_addr      = '0;
      sb_if.st_data      = '0;
      sb_if.st_length    = '0;
      sb_if.data_addr_ok = 1'b0;
      sb_if.data_data_ok = 1'b0;

      #12;
      check("rst_st_ready", 32'(sb_if.st_ready), 32'd1);
      check("rst_sb_empty", 32'(sb_if.sb_empty), 32'd1);
      check("rst_data_req", 32'(sb_if.data_req), 32'd0);
      check("rst_data_size", 32'(sb_if.data_size), 32'd0);
      check("rst_data_addr", sb_if.data_addr, 32'd0);
      check("rst_data_wdata", sb_if.data_wdata, 32'd0);
      check("rst_data_wstrb", 32'(sb_if.data_wstrb), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      cyc();

      // Byte store at lane 3, request visible the cycle after the push edge.
      push(32'h1003, 32'h0000_00A5, LEN_BYTE);
      check("sb_req", 32'(sb_if.data_req), 32'd1);
      check("sb_size", 32'(sb_if.data_size), 32'd0);
      check("sb_wdata", sb_if.data_wdata, 32'hA5A5_A5A5);
      check("sb_wstrb", 32'(sb_if.data_wstrb), 32'b1000);
      drain(32'h1003);

      push(32'h2002, 32'h1234_BEEF, LEN_HALF);
      check("sh_size", 32'(sb_if.data_size), 32'd1);
      check("sh_wdata", sb_if.data_wdata, 32'hBEEF_BEEF);
      check("sh_wstrb", 32'(sb_if.data_wstrb), 32'b1100);
      drain(32'h2002);

      // Misaligned word: flagged and dropped.
      sb_if.st_valid  = 1'b1;
      sb_if.st_addr   = 32'h3001;
      sb_if.st_data   = 32'hDEAD_BEEF;
      sb_if.st_length = LEN_WORD;
      #1;
      check("sw_ades", 32'(sb_if.st_ades), 32'd1);
      cyc();
      sb_if.st_valid = 1'b0;
      check("sw_no_req", 32'(sb_if.data_req), 32'd0);
      check("sw_empty", 32'(sb_if.sb_empty), 32'd1);

      // Fill to full with handshakes held low, then a rejected fifth store.
      for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 4), 32'h1111_0000 + 32'(i), LEN_WORD);
      check("full_ready", 32'(sb_if.st_ready), 32'd0);
      push(32'h110, 32'h5555_5555, LEN_WORD);
      check("full_head", sb_if.data_addr, 32'h100);
      for (int i = 0; i < 4; i++) drain(32'h100 + 32'(i * 4));
      check("full_drained", 32'(sb_if.sb_empty), 32'd1);

      // Push and pop together at count 2, enough times to wrap the pointers.
      push(32'h5000, 32'hA000_0000, LEN_WORD);
      push(32'h5004, 32'hA000_0001, LEN_WORD);
      for (int k = 0; k < 10; k++) begin
         accept();
         sb_if.data_data_ok = 1'b1;
         sb_if.st_valid     = 1'b1;
         sb_if.st_addr      = wrap_addr(k);
         sb_if.st_data      = 32'hA0B0_C000 + 32'(k);
         sb_if.st_length    = 2'(k % 3);
         cyc();
         sb_if.data_data_ok = 1'b0;
         sb_if.st_valid     = 1'b0;
      end
      check("wrap_ready", 32'(sb_if.st_ready), 32'd1);
      drain(wrap_addr(8));
      drain(wrap_addr(9));
      check("wrap_empty", 32'(sb_if.sb_empty), 32'd1);

      // Slow addr_ok with a stray data_ok while idle.
      push(32'h8008, 32'h0000_CAFE, LEN_HALF);
      cyc();
      sb_if.data_data_ok = 1'b1;
      cyc();
      sb_if.data_data_ok = 1'b0;
      check("idle_dok_req", 32'(sb_if.data_req), 32'd1);
      check("idle_dok_addr", sb_if.data_addr, 32'h8008);
      check("idle_dok_wdata", sb_if.data_wdata, 32'hCAFE_CAFE);
      cyc();
      drain(32'h8008);

      // Reset while waiting for completion with three entries queued.
      push(32'h7000, 32'h7000_0000, LEN_WORD);
      push(32'h7004, 32'h7000_0004, LEN_WORD);
      push(32'h7008, 32'h7000_0008, LEN_WORD);
      accept();
      #2;
      resetn = 1'b0;
      #1;
      check("arst_req", 32'(sb_if.data_req), 32'd0);
      check("arst_empty", 32'(sb_if.sb_empty), 32'd1);
      check("arst_ready", 32'(sb_if.st_ready), 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      sb_if.data_data_ok = 1'b1;
      cyc();
      sb_if.data_data_ok = 1'b0;
      check("late_dok_empty", 32'(sb_if.sb_empty), 32'd1);
      check("late_dok_req", 32'(sb_if.data_req), 32'd0);
      push(32'h7100, 32'h0000_0042, LEN_BYTE);
      check("post_rst_req", 32'(sb_if.data_req), 32'd1);
      check("post_rst_wdata", sb_if.data_wdata, 32'h4242_4242);
      drain(32'h7100);
      cyc();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
